// File: rtl/rv64_defs_pkg.sv
// Shared RV64I definitions: opcodes, funct3 codes, instruction field positions
// and the EX-stage control struct used by the issue/regfile block.
package rv64_defs;
  localparam int XLEN = 64;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  localparam int OPC_LSB = 0;
  localparam int RD_LSB  = 7;
  localparam int F3_LSB  = 12;
  localparam int RS1_LSB = 15;
  localparam int RS2_LSB = 20;
  localparam int IMM_LSB = 20;
  localparam int F7_LSB  = 25;

  typedef struct packed {
    logic       valid;
    logic       legal;
    logic [4:0] rd;
  } ex_ctl_t;

  // Immediate shifts carry a 6-bit shamt and keep funct7 (bit 30 picks SRAI).
  function automatic logic is_shift_imm(input logic [2:0] f3);
    return (f3 == F3_SLL) || (f3 == F3_SR);
  endfunction
endpackage

// File: rtl/regfile_2r1w.sv
// Architectural register file: two read ports plus a debug read port, one
// synchronous write port; x0 always reads as zero.
module regfile_2r1w #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   raddr1,
  output logic [XLEN-1:0] rdata1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata2,
  input  logic [AW-1:0]   dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata
);
  logic [NREGS-1:0][XLEN-1:0] regs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    regs <= '0;
    else if (we && waddr != '0)   regs[waddr] <= wdata;
  end

  assign rdata1    = (raddr1    == '0) ? '0 : regs[raddr1];
  assign rdata2    = (raddr2    == '0) ? '0 : regs[raddr2];
  assign dbg_rdata = (dbg_raddr == '0) ? '0 : regs[dbg_raddr];
endmodule

// File: rtl/rv64_issue_regfile.sv
// Operand supply and writeback for the RV64I integer ALU: decode, immediate
// generation, EX-result forwarding, the EX register and the retire register.
module rv64_issue_regfile #(
  parameter int XLEN  = rv64_defs::XLEN,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [31:0]     issue_instr,
  input  logic            ex_stall,
  output logic [31:0]     alu_instr,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  input  logic [XLEN-1:0] alu_out,
  output logic            retire_valid,
  output logic [4:0]      retire_rd,
  output logic [XLEN-1:0] retire_data,
  output logic            illegal,
  input  logic [4:0]      dbg_raddr,
  output logic [XLEN-1:0] dbg_rdata
);
  import rv64_defs::*;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] rf_rd1, rf_rd2, rs1_val, rs2_val;
  logic [XLEN-1:0] imm_ext, shamt_ext, dec_in2;
  logic [31:0]     dec_instr;
  logic            dec_legal, accept, fwd_en, wb_fire, rf_we;
  ex_ctl_t         ex;

  assign opcode = issue_instr[OPC_LSB +: 7];
  assign funct3 = issue_instr[F3_LSB  +: 3];
  assign rs1    = issue_instr[RS1_LSB +: 5];
  assign rs2    = issue_instr[RS2_LSB +: 5];
  assign rd     = issue_instr[RD_LSB  +: 5];

  assign issue_ready = ~ex_stall;
  assign accept      = issue_valid && issue_ready;
  assign wb_fire     = ex.valid && !ex_stall;
  assign fwd_en      = wb_fire && ex.legal;
  assign rf_we       = fwd_en && (ex.rd != 5'd0);

  regfile_2r1w #(.XLEN(XLEN), .NREGS(NREGS), .AW(5)) u_rf (
    .clk       (clk),
    .reset     (reset),
    .raddr1    (rs1),
    .rdata1    (rf_rd1),
    .raddr2    (rs2),
    .rdata2    (rf_rd2),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata),
    .we        (rf_we),
    .waddr     (ex.rd),
    .wdata     (alu_out)
  );

  // The EX result is not in the file yet when a dependent op issues right behind it.
  always_comb begin
    rs1_val = rf_rd1;
    if (rs1 == 5'd0)                     rs1_val = '0;
    else if (fwd_en && ex.rd == rs1)     rs1_val = alu_out;
    rs2_val = rf_rd2;
    if (rs2 == 5'd0)                     rs2_val = '0;
    else if (fwd_en && ex.rd == rs2)     rs2_val = alu_out;
  end

  assign imm_ext   = {{(XLEN-12){issue_instr[31]}}, issue_instr[IMM_LSB +: 12]};
  assign shamt_ext = {{(XLEN-6){1'b0}}, issue_instr[IMM_LSB +: 6]};

  always_comb begin
    dec_legal = 1'b0;
    dec_instr = issue_instr;
    dec_in2   = rs2_val;
    unique case (opcode)
      OPC_OP: dec_legal = 1'b1;
      OPC_OP_IMM: begin
        dec_legal = 1'b1;
        if (is_shift_imm(funct3)) begin
          dec_in2 = shamt_ext;
        end else begin
          dec_in2 = imm_ext;
          // imm[10] lands on bit 30; clear funct7 so ADDI never looks like SUB.
          dec_instr[31:F7_LSB] = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex        <= '0;
      alu_instr <= '0;
      alu_in1   <= '0;
      alu_in2   <= '0;
    end else if (!ex_stall) begin
      ex.valid <= accept;
      if (accept) begin
        ex.legal  <= dec_legal;
        ex.rd     <= rd;
        alu_instr <= dec_instr;
        alu_in1   <= rs1_val;
        alu_in2   <= dec_in2;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_valid <= 1'b0;
      retire_rd    <= '0;
      retire_data  <= '0;
      illegal      <= 1'b0;
    end else begin
      retire_valid <= wb_fire && ex.legal;
      illegal      <= wb_fire && !ex.legal;
      if (wb_fire && ex.legal) begin
        retire_rd   <= ex.rd;
        retire_data <= (ex.rd == 5'd0) ? '0 : alu_out;
      end
    end
  end
endmodule

// File: tb/tb_rv64_issue_regfile.sv
// Directed bench: a behavioural ALU closes the loop, a scoreboard queue holds
// expected retirements and a monitor checks every retire/illegal pulse.
module tb_rv64_issue_regfile;
  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic            issue_valid, issue_ready, ex_stall;
  logic [31:0]     issue_instr, alu_instr;
  logic [XLEN-1:0] alu_in1, alu_in2, alu_out, retire_data, dbg_rdata;
  logic            retire_valid, illegal;
  logic [4:0]      retire_rd, dbg_raddr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic            ill;
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  rv64_issue_regfile #(.XLEN(XLEN), .NREGS(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_instr  (issue_instr),
    .ex_stall     (ex_stall),
    .alu_instr    (alu_instr),
    .alu_in1      (alu_in1),
    .alu_in2      (alu_in2),
    .alu_out      (alu_out),
    .retire_valid (retire_valid),
    .retire_rd    (retire_rd),
    .retire_data  (retire_data),
    .illegal      (illegal),
    .dbg_raddr    (dbg_raddr),
    .dbg_rdata    (dbg_rdata)
  );

  // Reference ALU: uses bit 30 for SUB on any funct3=0 op, as a real ALU might.
  always_comb begin
    alu_out = '0;
    case (alu_instr[14:12])
      3'd0: alu_out = alu_instr[30] ? alu_in1 - alu_in2 : alu_in1 + alu_in2;
      3'd1: alu_out = alu_in1 << alu_in2[5:0];
      3'd2: alu_out = {63'd0, $signed(alu_in1) < $signed(alu_in2)};
      3'd3: alu_out = {63'd0, alu_in1 < alu_in2};
      3'd4: alu_out = alu_in1 ^ alu_in2;
      3'd5: alu_out = alu_instr[30] ? XLEN'($signed(alu_in1) >>> alu_in2[5:0])
                                    : alu_in1 >> alu_in2[5:0];
      3'd6: alu_out = alu_in1 | alu_in2;
      3'd7: alu_out = alu_in1 & alu_in2;
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (retire_valid || illegal)) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_retire: got rv=%0b ill=%0b rd=%0d expected no pulse",
                 retire_valid, illegal, retire_rd);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.ill) begin
          chk("illegal_pulse", {62'd0, illegal, retire_valid}, 64'd2);
        end else begin
          chk("retire_flags", {62'd0, illegal, retire_valid}, 64'd1);
          chk("retire_rd", {59'd0, retire_rd}, {59'd0, mon_e.rd});
          chk("retire_data", retire_data, mon_e.data);
        end
      end
    end
  end

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  task automatic send(input logic [31:0] ins, input bit push, input logic ill,
                      input logic [4:0] rd, input logic [XLEN-1:0] d);
    issue_valid = 1'b1;
    issue_instr = ins;
    if (push) sb.push_back({ill, rd, d});
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reg(input string name, input logic [4:0] a, input logic [XLEN-1:0] exp);
    dbg_raddr = a;
    #1;
    chk(name, dbg_rdata, exp);
  endtask

  initial begin
    reset       = 1'b1;
    issue_valid = 1'b0;
    issue_instr = '0;
    ex_stall    = 1'b0;
    dbg_raddr   = '0;
    idle(2);
    chk("rst_alu_in1", alu_in1, '0);
    chk("rst_alu_in2", alu_in2, '0);
    chk("rst_alu_instr", {32'd0, alu_instr}, '0);
    chk("rst_retire", {62'd0, illegal, retire_valid}, '0);
    chk("rst_retire_data", retire_data, '0);
    reset = 1'b0;
    #1;
    chk("rst_issue_ready", {63'd0, issue_ready}, 64'd1);

    // addi x1,x0,5
    send(itype(12'd5, 5'd0, 3'd0, 5'd1), 1, 0, 5'd1, 64'd5);
    chk("addi_in1", alu_in1, 64'd0);
    chk("addi_in2", alu_in2, 64'd5);
    idle(1);
    chk_reg("addi_x1", 5'd1, 64'd5);

    // addi x1,x0,-1024: funct7 must be cleared or the ALU subtracts
    send(itype(12'hC00, 5'd0, 3'd0, 5'd1), 1, 0, 5'd1, 64'hFFFF_FFFF_FFFF_FC00);
    chk("addi_neg_f7", {57'd0, alu_instr[31:25]}, 64'd0);
    chk("addi_neg_in2", alu_in2, 64'hFFFF_FFFF_FFFF_FC00);
    idle(1);
    chk_reg("addi_neg_x1", 5'd1, 64'hFFFF_FFFF_FFFF_FC00);

    // addi x1,x0,7 ; add x2,x1,x1 back to back
    send(itype(12'd7, 5'd0, 3'd0, 5'd1), 1, 0, 5'd1, 64'd7);
    send(rtype(7'd0, 5'd1, 5'd1, 3'd0, 5'd2), 1, 0, 5'd2, 64'd14);
    chk("fwd_in1", alu_in1, 64'd7);
    chk("fwd_in2", alu_in2, 64'd7);
    idle(1);
    chk_reg("fwd_x2", 5'd2, 64'd14);
    chk_reg("fwd_x1", 5'd1, 64'd7);

    // x3 = 1 ; slli x3,x3,63 ; srai x3,x3,63
    send(itype(12'd1, 5'd0, 3'd0, 5'd3), 1, 0, 5'd3, 64'd1);
    send(itype(12'h03F, 5'd3, 3'd1, 5'd3), 1, 0, 5'd3, 64'h8000_0000_0000_0000);
    send(itype(12'h43F, 5'd3, 3'd5, 5'd3), 1, 0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("srai_in1", alu_in1, 64'h8000_0000_0000_0000);
    chk("srai_in2", alu_in2, 64'd63);
    chk("srai_bit30", {63'd0, alu_instr[30]}, 64'd1);
    idle(1);
    chk_reg("srai_x3", 5'd3, 64'hFFFF_FFFF_FFFF_FFFF);

    // addi x0,x0,9 retires with data 0
    send(itype(12'd9, 5'd0, 3'd0, 5'd0), 1, 0, 5'd0, 64'd0);
    idle(1);
    chk_reg("x0_zero", 5'd0, 64'd0);

    // load opcode is illegal: pulse, no write to x5
    send({12'd0, 5'd1, 3'b011, 5'd5, 7'b0000011}, 1, 1, 5'd0, 64'd0);
    idle(1);
    chk_reg("illegal_x5", 5'd5, 64'd0);
    chk_reg("illegal_x1", 5'd1, 64'd7);
    idle(1);

    // stall three cycles with addi x4,x0,33 in EX; a pending issue is ignored
    send(itype(12'd33, 5'd0, 3'd0, 5'd4), 1, 0, 5'd4, 64'd33);
    ex_stall    = 1'b1;
    issue_valid = 1'b1;
    issue_instr = itype(12'd1, 5'd0, 3'd0, 5'd6);
    #1;
    chk("stall_ready", {63'd0, issue_ready}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("stall_no_retire", {62'd0, illegal, retire_valid}, 64'd0);
      chk("stall_hold_in2", alu_in2, 64'd33);
      chk_reg("stall_no_write", 5'd4, 64'd0);
    end
    ex_stall    = 1'b0;
    issue_valid = 1'b0;
    #1;
    chk("unstall_ready", {63'd0, issue_ready}, 64'd1);
    idle(1);
    chk_reg("unstall_x4", 5'd4, 64'd33);
    idle(2);
    chk_reg("stall_ignored_x6", 5'd6, 64'd0);

    // reset with addi x7,x0,3 in EX: dropped, everything back to 0
    send(itype(12'd3, 5'd0, 3'd0, 5'd7), 0, 0, 5'd0, 64'd0);
    reset = 1'b1;
    #1;
    chk("midrst_in2", alu_in2, '0);
    chk("midrst_instr", {32'd0, alu_instr}, '0);
    chk("midrst_retire_data", retire_data, '0);
    chk_reg("midrst_x1", 5'd1, 64'd0);
    idle(1);
    reset = 1'b0;
    idle(2);
    chk("midrst_no_retire", {62'd0, illegal, retire_valid}, 64'd0);
    chk_reg("midrst_x7", 5'd7, 64'd0);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
